// File: rtl/pio_irq_pkg.sv
// Shared constants for the pio_irq_ctrl Avalon-MM parallel I/O block.
// Register map, bus width and edge-select encoding.
package pio_irq_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_IN       = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OUT      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_INFO     = 3'd7;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // Cycles after reset release before edge detection is armed
  localparam logic [1:0] ARM_DONE = 2'd3;

  function automatic logic [DATA_W-1:0] info_word(
    input int unsigned in_w,
    input int unsigned out_w
  );
    return {16'h0000, in_w[7:0], out_w[7:0]};
  endfunction

endpackage

// File: rtl/pio_in_channel.sv
// One input channel: 2-flop sync, optional debounce, edge detect.
// Debounce present when PIO_IRQ_CTRL_DEBOUNCE_EN is defined.
module pio_in_channel
  import pio_irq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic edge_sel,
  input  logic det_en,
  output logic level,
  output logic edge_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic edge_q, edge_d;
  logic filt;

`ifdef PIO_IRQ_CTRL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d;

  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = CNT_MAX;
      filt_d = sync2_q;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  logic unused_db;
  assign unused_db = ^DEBOUNCE_CYCLES;
  assign filt = sync2_q;
`endif

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    prev_d  = filt;
    edge_d  = 1'b0;
    if (det_en) begin
      if (edge_sel == EDGE_FALL) edge_d = prev_q & ~filt;
      else                       edge_d = filt & ~prev_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
    end
  end

  assign level      = filt;
  assign edge_pulse = edge_q;

endmodule

// File: rtl/pio_irq_ctrl.sv
// Avalon-MM parallel I/O with set/clear outputs and edge interrupts.
// Input debounce enabled by defining PIO_IRQ_CTRL_DEBOUNCE_EN.
module pio_irq_ctrl
  import pio_irq_pkg::*;
#(
  parameter int unsigned OUT_W           = 8,
  parameter int unsigned IN_W            = 4,
  parameter logic [OUT_W-1:0] OUT_RESET  = '0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  input  logic [IN_W-1:0]   pio_in,
  output logic [OUT_W-1:0]  pio_out,
  output logic              irq
);

  logic [OUT_W-1:0]  out_q, out_d;
  logic [IN_W-1:0]   mask_q, mask_d;
  logic [IN_W-1:0]   cap_q, cap_d;
  logic [IN_W-1:0]   sel_q, sel_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        arm_q, arm_d;

  logic [IN_W-1:0]   in_lvl;
  logic [IN_W-1:0]   in_edge;
  logic [IN_W-1:0]   w1c;
  logic [DATA_W-1:0] rd_word;
  logic              det_en;

  logic [OUT_W-1:0]  wdata_o;
  logic [IN_W-1:0]   wdata_i;
  logic              wr_out, wr_set, wr_clr;
  logic              wr_mask, wr_cap, wr_sel;

  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  assign det_en = (arm_q == ARM_DONE);

  for (genvar i = 0; i < int'(IN_W); i++) begin : g_ch
    pio_in_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .pin       (pio_in[i]),
      .edge_sel  (sel_q[i]),
      .det_en    (det_en),
      .level     (in_lvl[i]),
      .edge_pulse(in_edge[i])
    );
  end

  assign wdata_o = avs_writedata[OUT_W-1:0];
  assign wdata_i = avs_writedata[IN_W-1:0];

  assign wr_out  = avs_write && (avs_address == ADDR_OUT);
  assign wr_set  = avs_write && (avs_address == ADDR_OUTSET);
  assign wr_clr  = avs_write && (avs_address == ADDR_OUTCLR);
  assign wr_mask = avs_write && (avs_address == ADDR_IRQ_MASK);
  assign wr_cap  = avs_write && (avs_address == ADDR_EDGE_CAP);
  assign wr_sel  = avs_write && (avs_address == ADDR_EDGE_SEL);

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    sel_d  = sel_q;
    w1c    = '0;
    unique case (1'b1)
      wr_out:  out_d  = wdata_o;
      wr_set:  out_d  = out_q | wdata_o;
      wr_clr:  out_d  = out_q & ~wdata_o;
      wr_mask: mask_d = wdata_i;
      wr_cap:  w1c    = wdata_i;
      wr_sel:  sel_d  = wdata_i;
      default: ;
    endcase
    // A new edge wins over a same-cycle clear of that bit
    cap_d = (cap_q & ~w1c) | in_edge;
    irq_d = |(cap_q & mask_q);
    arm_d = det_en ? arm_q : arm_q + 2'd1;
  end

  always_comb begin
    rd_word = '0;
    unique case (avs_address)
      ADDR_IN:       rd_word[IN_W-1:0]  = in_lvl;
      ADDR_OUT:      rd_word[OUT_W-1:0] = out_q;
      ADDR_IRQ_MASK: rd_word[IN_W-1:0]  = mask_q;
      ADDR_EDGE_CAP: rd_word[IN_W-1:0]  = cap_q;
      ADDR_EDGE_SEL: rd_word[IN_W-1:0]  = sel_q;
      ADDR_INFO:     rd_word = info_word(IN_W, OUT_W);
      default:       rd_word = '0;
    endcase
    rdata_d = avs_read ? rd_word : rdata_q;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      out_q   <= OUT_RESET;
      mask_q  <= '0;
      cap_q   <= '0;
      sel_q   <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
      arm_q   <= '0;
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      sel_q   <= sel_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
      arm_q   <= arm_d;
    end
  end

  assign pio_out      = out_q;
  assign irq          = irq_q;
  assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_pio_irq_ctrl.sv
// Self-checking bench for pio_irq_ctrl: vector table, corner sequences,
// and randomized traffic against a register-level model.
module tb_pio_irq_ctrl;
  import pio_irq_pkg::*;

  localparam int OUT_W = 8;
  localparam int IN_W  = 4;
  localparam int DB    = 16;
`ifdef PIO_IRQ_CTRL_DEBOUNCE_EN
  localparam int LAT = DB;
`else
  localparam int LAT = 0;
`endif
  localparam logic [7:0] OUT_RST = 8'h3C;

  logic        clk;
  logic        rst;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [3:0]  pio_in;
  logic [7:0]  pio_out;
  logic        irq;

  pio_irq_ctrl #(
    .OUT_W(OUT_W),
    .IN_W(IN_W),
    .OUT_RESET(OUT_RST),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .pio_in       (pio_in),
    .pio_out      (pio_out),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[20];

  logic [7:0] m_out;
  logic [3:0] m_mask, m_cap, m_sel, m_pin;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d = avs_readdata;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {28'h0, m_pin};
      3'd1:    return {24'h0, m_out};
      3'd4:    return {28'h0, m_mask};
      3'd5:    return {28'h0, m_cap};
      3'd6:    return {28'h0, m_sel};
      3'd7:    return 32'h0000_0408;
      default: return 32'h0;
    endcase
  endfunction

  logic [31:0] rd;

  initial begin
    tbl[0]  = '{1'b0, ADDR_INFO,     32'h0,        32'h0000_0408};
    tbl[1]  = '{1'b1, ADDR_OUT,      32'hA5,       32'hA5};
    tbl[2]  = '{1'b1, ADDR_OUTSET,   32'h0F,       32'hAF};
    tbl[3]  = '{1'b1, ADDR_OUTCLR,   32'h81,       32'h2E};
    tbl[4]  = '{1'b0, ADDR_OUT,      32'h0,        32'h2E};
    tbl[5]  = '{1'b0, ADDR_OUTSET,   32'h0,        32'h0};
    tbl[6]  = '{1'b0, ADDR_OUTCLR,   32'h0,        32'h0};
    tbl[7]  = '{1'b1, ADDR_INFO,     32'hFFFF,     32'h2E};
    tbl[8]  = '{1'b0, ADDR_INFO,     32'h0,        32'h0000_0408};
    tbl[9]  = '{1'b1, ADDR_OUT,      32'hFFFF_FF12, 32'h12};
    tbl[10] = '{1'b0, ADDR_OUT,      32'h0,        32'h12};
    tbl[11] = '{1'b1, ADDR_IRQ_MASK, 32'hFFFF_FFFF, 32'h12};
    tbl[12] = '{1'b0, ADDR_IRQ_MASK, 32'h0,        32'hF};
    tbl[13] = '{1'b1, ADDR_EDGE_SEL, 32'h5A,       32'h12};
    tbl[14] = '{1'b0, ADDR_EDGE_SEL, 32'h0,        32'hA};
    tbl[15] = '{1'b1, ADDR_IN,       32'hFF,       32'h12};
    tbl[16] = '{1'b0, ADDR_IN,       32'h0,        32'h0};
    tbl[17] = '{1'b1, ADDR_EDGE_SEL, 32'h0,        32'h12};
    tbl[18] = '{1'b1, ADDR_IRQ_MASK, 32'h0,        32'h12};
    tbl[19] = '{1'b0, ADDR_IRQ_MASK, 32'h0,        32'h0};

    rst = 1'b1;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    pio_in = 4'h0;
`ifndef PIO_IRQ_CTRL_DEBOUNCE_EN
    pio_in = 4'hF;
`endif
    wait_cyc(3);
    check("rst_pio_out", {24'h0, pio_out}, {24'h0, OUT_RST});
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    rst = 1'b0;
    wait_cyc(10);
`ifndef PIO_IRQ_CTRL_DEBOUNCE_EN
    bus_read(ADDR_EDGE_CAP, rd);
    check("no_edge_after_reset", rd, 32'h0);
    pio_in = 4'h0;
    wait_cyc(6);
`endif

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].addr, tbl[i].data);
        check($sformatf("tbl%0d_out", i), {24'h0, pio_out}, tbl[i].exp);
      end else begin
        bus_read(tbl[i].addr, rd);
        check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp);
      end
    end

    // read and write in the same cycle
    @(negedge clk);
    avs_address = ADDR_OUT;
    avs_writedata = 32'h55;
    avs_write = 1'b1;
    avs_read = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    avs_read = 1'b0;
    check("rw_same_rd", avs_readdata, 32'h12);
    check("rw_same_out", {24'h0, pio_out}, 32'h55);

    // rising edge latency on channel 0
    bus_write(ADDR_IRQ_MASK, 32'h1);
    @(negedge clk);
    pio_in[0] = 1'b1;
    @(posedge clk);
    repeat (3 + LAT) @(posedge clk);
    #1 check("irq_k3", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 check("irq_k4", {31'h0, irq}, 32'h1);
    bus_read(ADDR_EDGE_CAP, rd);
    check("cap_rise", rd, 32'h1);
    bus_write(ADDR_EDGE_CAP, 32'h1);
    check("irq_at_w1c", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1 check("irq_after_w1c", {31'h0, irq}, 32'h0);
    pio_in[0] = 1'b0;
    wait_cyc(6 + LAT);

    // falling edge select on channel 1, masked until later
    bus_write(ADDR_EDGE_SEL, 32'h2);
    @(negedge clk);
    pio_in[1] = 1'b1;
    wait_cyc(6 + LAT);
    bus_read(ADDR_EDGE_CAP, rd);
    check("fall_ignores_rise", rd, 32'h0);
    pio_in[1] = 1'b0;
    wait_cyc(6 + LAT);
    bus_read(ADDR_EDGE_CAP, rd);
    check("fall_cap", rd, 32'h2);
    check("fall_masked_irq", {31'h0, irq}, 32'h0);
    bus_write(ADDR_IRQ_MASK, 32'h2);
    check("irq_before_unmask", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 check("irq_unmask", {31'h0, irq}, 32'h1);
    bus_write(ADDR_EDGE_CAP, 32'h2);
    bus_write(ADDR_EDGE_SEL, 32'h0);
    bus_write(ADDR_IRQ_MASK, 32'h1);
    wait_cyc(2);
    check("irq_cleanup", {31'h0, irq}, 32'h0);

    // W1C in the same cycle as a new capture on channel 0
    @(negedge clk);
    pio_in[0] = 1'b1;
    wait_cyc(6 + LAT);
    check("irq_pre_same", {31'h0, irq}, 32'h1);
    pio_in[0] = 1'b0;
    wait_cyc(6 + LAT);
    pio_in[0] = 1'b1;
    @(posedge clk);
    repeat (2 + LAT) @(posedge clk);
    @(negedge clk);
    avs_address = ADDR_EDGE_CAP;
    avs_writedata = 32'h1;
    avs_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    avs_write = 1'b0;
    @(posedge clk);
    #1 check("irq_same_cycle", {31'h0, irq}, 32'h1);
    bus_read(ADDR_EDGE_CAP, rd);
    check("cap_same_cycle", rd, 32'h1);
    pio_in[0] = 1'b0;
    wait_cyc(6 + LAT);
    bus_write(ADDR_EDGE_CAP, 32'h1);
    wait_cyc(2);
    check("irq_clear2", {31'h0, irq}, 32'h0);

`ifdef PIO_IRQ_CTRL_DEBOUNCE_EN
    @(negedge clk);
    pio_in[2] = 1'b1;
    wait_cyc(10);
    pio_in[2] = 1'b0;
    wait_cyc(30);
    bus_read(ADDR_IN, rd);
    check("glitch_in", rd, 32'h0);
    bus_read(ADDR_EDGE_CAP, rd);
    check("glitch_cap", rd, 32'h0);
    @(negedge clk);
    pio_in[2] = 1'b1;
    wait_cyc(18);
    bus_read(ADDR_IN, rd);
    check("pulse_in", rd, 32'h4);
    pio_in[2] = 1'b0;
    wait_cyc(30);
    bus_read(ADDR_EDGE_CAP, rd);
    check("pulse_cap", rd, 32'h4);
    bus_write(ADDR_EDGE_CAP, 32'h4);
`endif

    // randomized traffic against the register-level model
    bus_write(ADDR_EDGE_SEL, 32'h0);
    pio_in = 4'h0;
    wait_cyc(6 + LAT);
    bus_write(ADDR_EDGE_CAP, 32'hF);
    bus_write(ADDR_IRQ_MASK, 32'h0);
    bus_write(ADDR_OUT, 32'h0);
    m_out = '0;
    m_mask = '0;
    m_cap = '0;
    m_sel = '0;
    m_pin = '0;
    for (int n = 0; n < 150; n++) begin
      logic [31:0] r;
      logic [3:0]  np;
      logic [2:0]  a;
      r = $urandom();
      case ($urandom_range(0, 7))
        0: begin
          bus_write(ADDR_OUT, r);
          m_out = r[7:0];
          check("rnd_out", {24'h0, pio_out}, {24'h0, m_out});
        end
        1: begin
          bus_write(ADDR_OUTSET, r);
          m_out = m_out | r[7:0];
          check("rnd_set", {24'h0, pio_out}, {24'h0, m_out});
        end
        2: begin
          bus_write(ADDR_OUTCLR, r);
          m_out = m_out & ~r[7:0];
          check("rnd_clr", {24'h0, pio_out}, {24'h0, m_out});
        end
        3: begin
          bus_write(ADDR_IRQ_MASK, r);
          m_mask = r[3:0];
          wait_cyc(1);
          check("rnd_mask_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        end
        4: begin
          bus_write(ADDR_EDGE_SEL, r);
          m_sel = r[3:0];
        end
        5: begin
          np = r[3:0];
          for (int c = 0; c < 4; c++)
            if (np[c] != m_pin[c] && (np[c] ? !m_sel[c] : m_sel[c]))
              m_cap[c] = 1'b1;
          @(negedge clk);
          pio_in = np;
          m_pin = np;
          wait_cyc(6 + LAT);
          check("rnd_pin_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        end
        6: begin
          bus_write(ADDR_EDGE_CAP, r);
          m_cap = m_cap & ~r[3:0];
          wait_cyc(1);
          check("rnd_w1c_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        end
        default: begin
          a = 3'($urandom_range(0, 7));
          bus_read(a, rd);
          check($sformatf("rnd_rd%0d", a), rd, model_read(a));
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
